// File: rtl/pe_array_feeder_if.sv
// Buffer read buses and PE-array input bundle for pe_array_feeder.
// master = feeder side, slave = buffers plus array side.
interface pe_array_feeder_if #(
  parameter int PIXEL = 8,
  parameter int X     = 32,
  parameter int RA_W  = 8
);
  logic                   curr_rd_en;
  logic [3:0]             curr_rd_addr;
  logic [2*X*PIXEL-1:0]   curr_rd_data;
  logic                   ref_rd_en;
  logic [RA_W-1:0]        ref_rd_addr;
  logic [8*X*PIXEL-1:0]   ref_rd_data;
  logic [2*X*PIXEL-1:0]   current_64pixels;
  logic                   in_curr_enable;
  logic                   CB_select;
  logic [1:0]             abs_Control;
  logic [8*X*PIXEL-1:0]   ref_8R_32;
  logic                   change_ref;
  logic                   ref_input_control;
  logic                   cand_valid;
  logic [7:0]             cand_off;

  modport master (
    output curr_rd_en, curr_rd_addr, ref_rd_en, ref_rd_addr,
    input  curr_rd_data, ref_rd_data,
    output current_64pixels, in_curr_enable, CB_select, abs_Control,
    output ref_8R_32, change_ref, ref_input_control, cand_valid, cand_off
  );

  modport slave (
    input  curr_rd_en, curr_rd_addr, ref_rd_en, ref_rd_addr,
    output curr_rd_data, ref_rd_data,
    input  current_64pixels, in_curr_enable, CB_select, abs_Control,
    input  ref_8R_32, change_ref, ref_input_control, cand_valid, cand_off
  );
endinterface

// File: rtl/pe_array_feeder.sv
// Producer side of the 32x32 PE array: streams the current block, then the
// reference search band, and flags each vertical candidate offset.
module pe_array_feeder #(
  parameter int PIXEL       = 8,
  parameter int X           = 32,
  parameter int SEARCH_ROWS = 64,
  parameter int RA_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cb_sel_in,
  input  logic [1:0]        abs_ctrl_in,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  pe_array_feeder_if.master bus
);
  localparam int          CURR_W   = 2 * X * PIXEL;
  localparam int          REF_W    = 8 * X * PIXEL;
  localparam logic [8:0]  LAST_ROW = 9'(SEARCH_ROWS - 1);
  localparam logic [8:0]  LAST_OFF = 9'(SEARCH_ROWS - 32);

  typedef enum logic [2:0] {IDLE, CURR, PRE, SRCH, FIN} state_t;

  state_t     state;
  logic [3:0] curr_cnt;
  logic [8:0] ref_row;
  logic [8:0] cand_cnt;
  logic       ref8_p0, cand_p0;
  logic       curr_vld_p1, ref_vld_p1, ref8_p1, cand_p1;
  logic       cand_p2;

  // p0: read issue; strobes and addresses are registered
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      curr_cnt          <= '0;
      ref_row           <= '0;
      ref8_p0           <= 1'b0;
      cand_p0           <= 1'b0;
      bus.curr_rd_en    <= 1'b0;
      bus.curr_rd_addr  <= '0;
      bus.ref_rd_en     <= 1'b0;
      bus.ref_rd_addr   <= '0;
      bus.CB_select     <= 1'b0;
      bus.abs_Control   <= '0;
    end else begin
      bus.curr_rd_en <= 1'b0;
      bus.ref_rd_en  <= 1'b0;
      ref8_p0        <= 1'b0;
      cand_p0        <= 1'b0;
      done           <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          bus.CB_select   <= cb_sel_in;
          bus.abs_Control <= abs_ctrl_in;
          busy            <= 1'b1;
          ref_row         <= '0;
          state           <= CURR;
          // The first line read goes out on the accepting edge itself.
          if (!hold) begin
            bus.curr_rd_en   <= 1'b1;
            bus.curr_rd_addr <= '0;
            curr_cnt         <= 4'd1;
          end else begin
            curr_cnt <= '0;
          end
        end
        CURR: if (!hold) begin
          bus.curr_rd_en   <= 1'b1;
          bus.curr_rd_addr <= curr_cnt;
          curr_cnt         <= curr_cnt + 4'd1;
          if (curr_cnt == 4'd15) state <= PRE;
        end
        PRE: if (!hold) begin
          bus.ref_rd_en   <= 1'b1;
          bus.ref_rd_addr <= RA_W'(ref_row);
          ref8_p0         <= 1'b1;
          // The 4th 8-row load completes the window for offset 0.
          cand_p0         <= (ref_row == 9'd24);
          if (ref_row == 9'd24) begin
            ref_row <= 9'd32;
            state   <= (SEARCH_ROWS == 32) ? FIN : SRCH;
          end else begin
            ref_row <= ref_row + 9'd8;
          end
        end
        SRCH: if (!hold) begin
          bus.ref_rd_en   <= 1'b1;
          bus.ref_rd_addr <= RA_W'(ref_row);
          cand_p0         <= 1'b1;
          if (ref_row == LAST_ROW) state   <= FIN;
          else                     ref_row <= ref_row + 9'd1;
        end
        FIN: if (cand_p2 && cand_cnt == LAST_OFF) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      curr_vld_p1           <= 1'b0;
      ref_vld_p1            <= 1'b0;
      ref8_p1               <= 1'b0;
      cand_p1               <= 1'b0;
      cand_p2               <= 1'b0;
      cand_cnt              <= '0;
      bus.in_curr_enable    <= 1'b0;
      bus.current_64pixels  <= {CURR_W{1'b0}};
      bus.change_ref        <= 1'b0;
      bus.ref_input_control <= 1'b0;
      bus.ref_8R_32         <= {REF_W{1'b0}};
      bus.cand_valid        <= 1'b0;
      bus.cand_off          <= '0;
    end else begin
      // p1: buffer data is on the read bus this cycle
      curr_vld_p1 <= bus.curr_rd_en;
      ref_vld_p1  <= bus.ref_rd_en;
      ref8_p1     <= ref8_p0;
      cand_p1     <= cand_p0;
      // p2: capture into the array-facing outputs
      bus.in_curr_enable    <= curr_vld_p1;
      bus.change_ref        <= ref_vld_p1;
      bus.ref_input_control <= ref_vld_p1 & ref8_p1;
      if (curr_vld_p1) bus.current_64pixels <= bus.curr_rd_data;
      if (ref_vld_p1)  bus.ref_8R_32        <= bus.ref_rd_data;
      cand_p2 <= cand_p1;
      // p3: candidate flag one cycle after its completing beat
      bus.cand_valid <= cand_p2;
      if (cand_p2) bus.cand_off <= cand_cnt[7:0];
      if (state == IDLE)  cand_cnt <= '0;
      else if (cand_p2)   cand_cnt <= cand_cnt + 9'd1;
    end
  end
endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder: nominal timing, byte mapping, hold,
// SEARCH_ROWS=32, ignored start, and mid-run reset.
module tb_pe_array_feeder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, cb_sel_in, hold, start32;
  logic [1:0] abs_ctrl_in;
  logic       busy, done, busy32, done32;
  int         n_cmp = 0;
  int         n_bad = 0;

  pe_array_feeder_if #(.PIXEL(8), .X(32), .RA_W(8)) bus ();
  pe_array_feeder_if #(.PIXEL(8), .X(32), .RA_W(8)) bus32 ();

  pe_array_feeder #(.PIXEL(8), .X(32), .SEARCH_ROWS(64), .RA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cb_sel_in(cb_sel_in),
    .abs_ctrl_in(abs_ctrl_in), .hold(hold), .busy(busy), .done(done),
    .bus(bus.master));

  pe_array_feeder #(.PIXEL(8), .X(32), .SEARCH_ROWS(32), .RA_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .cb_sel_in(1'b0),
    .abs_ctrl_in(2'b00), .hold(1'b0), .busy(busy32), .done(done32),
    .bus(bus32.master));

  // Buffer pattern: pixel (row, col) = (row*32 + col) mod 256, col 0 in the low byte.
  function automatic logic [511:0] line_data(input int l);
    logic [511:0] d;
    for (int c = 0; c < 32; c++) begin
      d[c*8 +: 8]       = 8'((2*l)*32 + c);
      d[256 + c*8 +: 8] = 8'((2*l+1)*32 + c);
    end
    return d;
  endfunction

  function automatic logic [2047:0] ref_data(input int a);
    logic [2047:0] d;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 32; c++)
        d[k*256 + c*8 +: 8] = 8'((a+k)*32 + c);
    return d;
  endfunction

  // Buffers return data one cycle after the strobe; filler otherwise.
  always @(posedge clk) begin
    bus.curr_rd_data   <= bus.curr_rd_en   ? line_data(int'(bus.curr_rd_addr))  : {64{8'hEE}};
    bus.ref_rd_data    <= bus.ref_rd_en    ? ref_data(int'(bus.ref_rd_addr))    : {256{8'hEE}};
    bus32.curr_rd_data <= bus32.curr_rd_en ? line_data(int'(bus32.curr_rd_addr)) : {64{8'hEE}};
    bus32.ref_rd_data  <= bus32.ref_rd_en  ? ref_data(int'(bus32.ref_rd_addr))  : {256{8'hEE}};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b1; start32 = 1'b1; cb_sel_in = 1'b1;
    abs_ctrl_in = 2'b11; hold = 1'b0;
    tick; tick;
    n_cmp++;
    if (busy !== 1'b0 || bus.curr_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL reset.busy_rd got %b%b want 00", busy, bus.curr_rd_en);
    end
    n_cmp++;
    if (bus.CB_select !== 1'b0 || bus.abs_Control !== 2'b00) begin
      n_bad++; $display("FAIL reset.latch got %b/%b want 0/00", bus.CB_select, bus.abs_Control);
    end
    n_cmp++;
    if (done !== 1'b0 || bus.change_ref !== 1'b0 || bus.cand_valid !== 1'b0 ||
        bus.in_curr_enable !== 1'b0 || bus.ref_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL reset.strobes got d%b cr%b cv%b ce%b rr%b want 0", done,
                        bus.change_ref, bus.cand_valid, bus.in_curr_enable, bus.ref_rd_en);
    end
    n_cmp++;
    if (bus.current_64pixels !== '0 || bus.ref_8R_32 !== '0 || bus.cand_off !== 8'd0) begin
      n_bad++; $display("FAIL reset.data got nonzero want 0");
    end
    start = 1'b0; start32 = 1'b0; cb_sel_in = 1'b0; abs_ctrl_in = 2'b00;
    rst_n = 1'b0;
    tick; tick;
  endtask

  task automatic test_nominal(input string tag);
    logic e;
    start = 1'b1; cb_sel_in = 1'b0; abs_ctrl_in = 2'b00; hold = 1'b0;
    for (int c = 0; c <= 58; c++) begin
      @(negedge clk);
      e = (c >= 1 && c <= 16);
      n_cmp++;
      if (bus.curr_rd_en !== e) begin
        n_bad++; $display("FAIL %s.curr_rd_en c=%0d got %b want %b", tag, c, bus.curr_rd_en, e);
      end
      if (e) begin
        n_cmp++;
        if (bus.curr_rd_addr !== 4'(c-1)) begin
          n_bad++; $display("FAIL %s.curr_rd_addr c=%0d got %0d want %0d", tag, c, bus.curr_rd_addr, c-1);
        end
      end
      e = (c >= 17 && c <= 52);
      n_cmp++;
      if (bus.ref_rd_en !== e) begin
        n_bad++; $display("FAIL %s.ref_rd_en c=%0d got %b want %b", tag, c, bus.ref_rd_en, e);
      end
      if (e) begin
        n_cmp++;
        if (bus.ref_rd_addr !== 8'((c <= 20) ? (c-17)*8 : c-21+32)) begin
          n_bad++; $display("FAIL %s.ref_rd_addr c=%0d got %0d want %0d", tag, c, bus.ref_rd_addr,
                            (c <= 20) ? (c-17)*8 : c-21+32);
        end
      end
      e = (c >= 3 && c <= 18);
      n_cmp++;
      if (bus.in_curr_enable !== e) begin
        n_bad++; $display("FAIL %s.in_curr_enable c=%0d got %b want %b", tag, c, bus.in_curr_enable, e);
      end
      if (e) begin
        n_cmp++;
        if (bus.current_64pixels !== line_data(c-3)) begin
          n_bad++; $display("FAIL %s.current_64pixels c=%0d got %h want line %0d", tag, c,
                            bus.current_64pixels[31:0], c-3);
        end
      end
      e = (c >= 19 && c <= 54);
      n_cmp++;
      if (bus.change_ref !== e) begin
        n_bad++; $display("FAIL %s.change_ref c=%0d got %b want %b", tag, c, bus.change_ref, e);
      end
      if (e) begin
        n_cmp++;
        if (bus.ref_input_control !== (c <= 22)) begin
          n_bad++; $display("FAIL %s.ref_input_control c=%0d got %b want %b", tag, c,
                            bus.ref_input_control, (c <= 22));
        end
      end
      e = (c >= 23 && c <= 55);
      n_cmp++;
      if (bus.cand_valid !== e) begin
        n_bad++; $display("FAIL %s.cand_valid c=%0d got %b want %b", tag, c, bus.cand_valid, e);
      end
      if (e) begin
        n_cmp++;
        if (bus.cand_off !== 8'(c-23)) begin
          n_bad++; $display("FAIL %s.cand_off c=%0d got %0d want %0d", tag, c, bus.cand_off, c-23);
        end
      end
      n_cmp++;
      if (done !== (c == 55) || busy !== (c >= 1 && c <= 54)) begin
        n_bad++; $display("FAIL %s.done_busy c=%0d got %b%b want %b%b", tag, c, done, busy,
                          (c == 55), (c >= 1 && c <= 54));
      end
      tick;
      start = 1'b0;
    end
  endtask

  task automatic test_byte_mapping;
    int ci = 0, ri = 0, a;
    start = 1'b1; hold = 1'b0;
    for (int c = 0; c <= 58; c++) begin
      @(negedge clk);
      if (bus.in_curr_enable === 1'b1) begin
        n_cmp++;
        if (bus.current_64pixels[256 + 17*8 +: 8] !== 8'((2*ci+1)*32 + 17) ||
            bus.current_64pixels[5*8 +: 8] !== 8'((2*ci)*32 + 5)) begin
          n_bad++; $display("FAIL map.curr line=%0d got hi17=%0d lo5=%0d want %0d/%0d", ci,
                            bus.current_64pixels[256+17*8 +: 8], bus.current_64pixels[5*8 +: 8],
                            8'((2*ci+1)*32+17), 8'((2*ci)*32+5));
        end
        ci++;
      end
      if (bus.change_ref === 1'b1) begin
        a = (ri < 4) ? 8*ri : 28 + ri;
        for (int k = 0; k < ((ri < 4) ? 8 : 1); k++) begin
          n_cmp++;
          if (bus.ref_8R_32[k*256 + 9*8 +: 8] !== 8'((a+k)*32 + 9)) begin
            n_bad++; $display("FAIL map.ref beat=%0d row=%0d got %0d want %0d", ri, k,
                              bus.ref_8R_32[k*256 + 9*8 +: 8], 8'((a+k)*32 + 9));
          end
        end
        ri++;
      end
      tick;
      start = 1'b0;
    end
    n_cmp++;
    if (ci !== 16 || ri !== 36) begin
      n_bad++; $display("FAIL map.beats got %0d/%0d want 16/36", ci, ri);
    end
  endtask

  task automatic test_hold;
    int ci = 0, ri = 0, cv = 0, cia = 0, ria = 0, done_c = -1;
    start = 1'b1; hold = 1'b0;
    for (int c = 0; c <= 66; c++) begin
      @(negedge clk);
      if (bus.curr_rd_en === 1'b1) begin
        n_cmp++;
        if (bus.curr_rd_addr !== 4'(cia)) begin
          n_bad++; $display("FAIL hold.curr_addr c=%0d got %0d want %0d", c, bus.curr_rd_addr, cia);
        end
        cia++;
      end
      if (bus.ref_rd_en === 1'b1) begin
        n_cmp++;
        if (bus.ref_rd_addr !== 8'((ria < 4) ? 8*ria : 28 + ria)) begin
          n_bad++; $display("FAIL hold.ref_addr c=%0d got %0d want %0d", c, bus.ref_rd_addr,
                            (ria < 4) ? 8*ria : 28 + ria);
        end
        ria++;
      end
      if (bus.in_curr_enable === 1'b1) begin
        n_cmp++;
        if (bus.current_64pixels !== line_data(ci)) begin
          n_bad++; $display("FAIL hold.curr_data c=%0d got %h want line %0d", c,
                            bus.current_64pixels[31:0], ci);
        end
        ci++;
      end
      if (bus.change_ref === 1'b1) begin
        n_cmp++;
        if (bus.ref_8R_32[255:0] !== ref_data((ri < 4) ? 8*ri : 28 + ri)[255:0] ||
            bus.ref_input_control !== (ri < 4)) begin
          n_bad++; $display("FAIL hold.ref_beat c=%0d beat=%0d got ctl %b row0 %h", c, ri,
                            bus.ref_input_control, bus.ref_8R_32[31:0]);
        end
        ri++;
      end
      if (bus.cand_valid === 1'b1) begin
        n_cmp++;
        if (bus.cand_off !== 8'(cv)) begin
          n_bad++; $display("FAIL hold.cand_off c=%0d got %0d want %0d", c, bus.cand_off, cv);
        end
        cv++;
      end
      if (done === 1'b1 && done_c < 0) done_c = c;
      tick;
      start = 1'b0;
      hold = ((c+1) >= 5 && (c+1) <= 7) || ((c+1) >= 30 && (c+1) <= 31);
    end
    hold = 1'b0;
    n_cmp++;
    if (ci !== 16 || ri !== 36 || cv !== 33) begin
      n_bad++; $display("FAIL hold.counts got %0d/%0d/%0d want 16/36/33", ci, ri, cv);
    end
    n_cmp++;
    if (done_c !== 60) begin
      n_bad++; $display("FAIL hold.done_cycle got %0d want 60", done_c);
    end
  endtask

  task automatic test_search32;
    int ci = 0, ri = 0, r8 = 0, cv = 0, done_c = -1;
    start32 = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (bus32.in_curr_enable === 1'b1) ci++;
      if (bus32.change_ref === 1'b1) begin
        ri++;
        if (bus32.ref_input_control === 1'b1) r8++;
      end
      if (bus32.cand_valid === 1'b1) begin
        cv++;
        n_cmp++;
        if (bus32.cand_off !== 8'd0 || c !== 23) begin
          n_bad++; $display("FAIL s32.cand c=%0d got off %0d want off 0 at 23", c, bus32.cand_off);
        end
      end
      if (done32 === 1'b1 && done_c < 0) done_c = c;
      tick;
      start32 = 1'b0;
    end
    n_cmp++;
    if (ci !== 16 || ri !== 4 || r8 !== 4 || cv !== 1) begin
      n_bad++; $display("FAIL s32.counts got %0d/%0d/%0d/%0d want 16/4/4/1", ci, ri, r8, cv);
    end
    n_cmp++;
    if (done_c !== 23 || busy32 !== 1'b0) begin
      n_bad++; $display("FAIL s32.done got cycle %0d busy %b want 23/0", done_c, busy32);
    end
  endtask

  task automatic test_start_ignored;
    int done_c = -1;
    start = 1'b1; cb_sel_in = 1'b1; abs_ctrl_in = 2'b10;
    for (int c = 0; c <= 58; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        n_cmp++;
        if (bus.CB_select !== 1'b1 || bus.abs_Control !== 2'b10) begin
          n_bad++; $display("FAIL ign.latch c=%0d got %b/%b want 1/10", c, bus.CB_select, bus.abs_Control);
        end
      end
      if (done === 1'b1 && done_c < 0) done_c = c;
      tick;
      start = ((c+1) == 10 || (c+1) == 30);
      if ((c+1) == 10) begin cb_sel_in = 1'b0; abs_ctrl_in = 2'b01; end
      if ((c+1) == 20) cb_sel_in = 1'b1;
      if ((c+1) == 30) cb_sel_in = 1'b0;
    end
    n_cmp++;
    if (done_c !== 55) begin
      n_bad++; $display("FAIL ign.done_cycle got %0d want 55", done_c);
    end
  endtask

  task automatic test_mid_reset;
    start = 1'b1; cb_sel_in = 1'b1; abs_ctrl_in = 2'b11;
    for (int c = 0; c <= 24; c++) begin
      tick;
      start = 1'b0;
    end
    rst_n = 1'b1;
    tick;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.curr_rd_en !== 1'b0 || bus.ref_rd_en !== 1'b0 ||
        bus.ref_rd_addr !== 8'd0 || bus.curr_rd_addr !== 4'd0) begin
      n_bad++; $display("FAIL mrst.ctrl got busy %b rr %b ra %0d want 0", busy, bus.ref_rd_en, bus.ref_rd_addr);
    end
    n_cmp++;
    if (bus.change_ref !== 1'b0 || bus.cand_valid !== 1'b0 || bus.cand_off !== 8'd0 ||
        bus.CB_select !== 1'b0 || bus.abs_Control !== 2'b00 || bus.ref_8R_32 !== '0 ||
        bus.current_64pixels !== '0 || bus.ref_input_control !== 1'b0) begin
      n_bad++; $display("FAIL mrst.outputs got cr %b cv %b cb %b row0 %h want 0", bus.change_ref,
                        bus.cand_valid, bus.CB_select, bus.ref_8R_32[31:0]);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      @(negedge clk);
      n_cmp++;
      if (bus.change_ref !== 1'b0 || bus.cand_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL mrst.drain c=%0d got cr %b cv %b busy %b want 0", c,
                          bus.change_ref, bus.cand_valid, busy);
      end
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_nominal("nominal");
    tick;
    test_byte_mapping();
    tick;
    test_hold();
    tick;
    test_search32();
    test_start_ignored();
    tick;
    test_mid_reset();
    test_nominal("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Producer side of the 32x32 PE array input interface.
- Fetches the current block (two 32-pixel rows per beat) and the reference search band from on-chip buffers.
- Drives the array's current-pixel, reference-pixel and shift-control inputs with correct ordering and timing.
- Flags each vertical candidate offset as the array is loaded, so the SAD tree knows when sums are meaningful.

Parameters:
- PIXEL, 8, bits per pixel.
- X, 32, pixels per row and rows per block.
- SEARCH_ROWS, 64, reference rows scanned vertically; legal range 32..255.
- RA_W, 8, reference row-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-high reset; the name follows the codebase, the polarity is fixed as stated.
- start  in  1  one-cycle request; accepted only in IDLE.
- cb_sel_in  in  1  block-pair select; latched at start.
- abs_ctrl_in  in  2  CB subtraction select; latched at start.
- hold  in  1  throttle; when high, no new read is issued that cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- curr_rd_en  out  1  current-block buffer read strobe.
- curr_rd_addr  out  4  line index 0..15.
- curr_rd_data  in  2*X*PIXEL  64 pixels, returned exactly 1 cycle after curr_rd_en.
- ref_rd_en  out  1  reference buffer read strobe.
- ref_rd_addr  out  RA_W  first row of 8 returned rows.
- ref_rd_data  in  8*X*PIXEL  rows addr..addr+7; row k at bits [(k+1)*256-1 : k*256]; 1-cycle latency.
- current_64pixels  out  2*X*PIXEL  to PE array.
- in_curr_enable  out  1  current-pixel shift beat.
- CB_select  out  1  latched cb_sel_in.
- abs_Control  out  2  latched abs_ctrl_in.
- ref_8R_32  out  8*X*PIXEL  to PE array.
- change_ref  out  1  reference shift beat.
- ref_input_control  out  1  1 = 8-row shift, 0 = 1-row shift (uses row 0 of ref_8R_32).
- cand_valid  out  1  the array holds the window for cand_off.
- cand_off  out  8  vertical offset 0..SEARCH_ROWS-32.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters cleared, in-flight read data discarded. Reset overrides start in the same cycle.
- FSM: IDLE -> CURR -> PRE -> SRCH -> FIN -> IDLE.
- IDLE: on start, latch cb_sel_in and abs_ctrl_in to CB_select and abs_Control, then go to CURR. start while busy is ignored.
- All read strobes and addresses are registered.
  - Data returns the next cycle and is registered into the data outputs.
  - The data beat therefore appears 2 cycles after the read strobe, with the matching enable or change_ref high for exactly that cycle.
- CURR: issue 16 reads, addr 0..15, one per non-hold cycle. After addr 15: go to PRE.
- PRE: issue 4 reads at row addrs 0, 8, 16, 24. Each produces a beat with change_ref=1 and ref_input_control=1. After the 4th: go to SRCH, or to FIN if SEARCH_ROWS==32.
- SRCH: issue reads at row addr 32..SEARCH_ROWS-1, one per non-hold cycle. Each produces a beat with change_ref=1 and ref_input_control=0. After the last: go to FIN.
- FIN: wait for the pipeline to drain.
  - done pulses in the cycle the final cand_valid is asserted.
  - busy drops in that same cycle.
  - Return to IDLE.
- Candidates:
  - cand_valid with cand_off=0 one cycle after the 4th PRE beat.
  - Each 1-row beat n (n=1..SEARCH_ROWS-32) yields cand_valid with cand_off=n one cycle later.
- hold: stalls issue only; reads already issued still deliver their beat. Outside a beat, in_curr_enable, change_ref and cand_valid are 0.
- Data outputs retain their last beat value between beats.
- Counters are sized so no wrap occurs within range. The row address never exceeds SEARCH_ROWS-1.

Test Plan:
- Nominal, SEARCH_ROWS=64, hold=0, start at cycle 0:
  - curr_rd_addr 0..15 in cycles 1..16.
  - in_curr_enable in cycles 3..18, carrying the line data.
  - change_ref in cycles 19..54; ref_input_control=1 in cycles 19..22.
  - cand_valid in cycles 23..55 with cand_off 0..32.
  - done at cycle 55.
- Byte mapping: buffer pattern with pixel = (row*32+col) mod 256 -> ref_8R_32 row k equals addr+k; current_64pixels upper half equals the second row of the line.
- hold=1 for cycles 5..7 and 30..31 -> exactly 16 curr and 36 ref beats total, no duplicates or drops, done delayed by 5 cycles.
- SEARCH_ROWS=32 -> 4 ref beats only, single cand_valid with cand_off=0, then done.
- start pulsed while busy, and start/cb_sel toggled mid-run -> ignored; CB_select and abs_Control stay at their latched values.
- rst_n asserted at cycle 25 -> all outputs 0 at cycle 26; a fresh start reproduces the nominal timing exactly.
